test_vector_sequencer: RTL and testbench
========================================

Name: test_vector_sequencer

Overview:
- Parametrised, programmable stimulus sequencer that drives register-file/ALU control fields (immediate, enables, Cin, op/exop) one vector at a time.
- Replaces a hard-coded per-state output FSM with a loadable vector table.
- Adds configurable dwell, sequence length, loop/one-shot, pause and single-step modes, and a DUT reset output.
- Sits between board buttons/host and the datapath under test.

Parameters:
- NUM_STEPS, 32, vector table depth; AW = $clog2(NUM_STEPS).
- DWELL, 50000000, clk cycles each vector is held in RUN (min 2); counter width = $clog2(DWELL).
- IMM_W, 16, immediate width.
- EN_W, 5, width of each enable bus.
- VEC_W, IMM_W+3*EN_W+10, table word = {imm, regEn, buffA, buffB, Cin, regOrImmed, op[3:0], exop[3:0]}, MSB first.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- vec_we  in  1  table write strobe
- vec_addr  in  AW  table write address
- vec_wdata  in  VEC_W  table write data
- wr_err  out  1  one-cycle pulse: write rejected
- last_step  in  AW  final step index, sampled on start
- loop_en  in  1  1 = wrap to step 0 after last_step, 0 = one-shot
- start  in  1  begin sequence (level, acted on in IDLE/DONE)
- stop  in  1  abort to IDLE
- pause  in  1  level; freeze dwell in RUN
- single_step  in  1  pulse; advance one step while paused
- cur_step  out  AW  index of vector on outputs
- step_strobe  out  1  one-cycle pulse when a new vector appears
- busy  out  1  high in RUN/PAUSE
- done  out  1  high in DONE
- loop_count  out  8  completed wraps, saturating at 255
- dut_reset_n  out  1  low in IDLE, high otherwise
- immediate  out  IMM_W
- regEnables, buffAEnables, buffBEnables  out  EN_W each
- Cin, regOrImmed  out  1 each
- op, exop  out  4 each

Behaviour:
- All outputs registered.
- Reset: state=IDLE, all control outputs 0, cur_step=0, loop_count=0, step_strobe/wr_err/busy/done=0, dut_reset_n=0, dwell counter 0.
- Table contents are not reset.
- States: IDLE, RUN, PAUSE, DONE. Priority each cycle: stop > start > single_step > pause > dwell expiry.
- IDLE:
  - vec_we writes table[vec_addr]; vec_addr >= NUM_STEPS is rejected (wr_err).
  - start -> RUN; latch last_step (clamped to NUM_STEPS-1); cur_step=0.
  - Vector 0 appears on outputs the cycle after start; step_strobe pulses the same cycle; dut_reset_n=1.
- RUN:
  - dwell counter increments from 0. At DWELL-1:
    - cur_step < last_step: advance, load next vector, strobe, counter=0.
    - cur_step == last_step, loop_en=1: cur_step=0, loop_count+1, strobe.
    - cur_step == last_step, loop_en=0: -> DONE.
  - Each vector is held exactly DWELL cycles.
- pause high in RUN -> PAUSE; counter frozen. pause low -> RUN, resuming the count.
- PAUSE: single_step pulse advances immediately with the same last-step/loop rules, resets counter to 0, stays in PAUSE (or -> DONE at end, one-shot).
- DONE: outputs hold the last vector; done=1. start restarts as from IDLE (loop_count cleared).
- stop in any non-IDLE state -> IDLE next cycle: control outputs 0, cur_step=0, dut_reset_n=0.
- start and stop in the same cycle: stop wins.
- vec_we outside IDLE is ignored, table unchanged, wr_err pulses 1 cycle.
- Reset asserted mid-sequence: immediate return to reset values; table retained.
- last_step=0: single vector; loop mode re-strobes step 0 every DWELL cycles.

Optional Feature:
- SEQ_BREAKPOINT_EN
- Defined: adds inputs bp_en (1) and bp_addr (AW). In RUN, when a vector whose index equals bp_addr is loaded and bp_en=1, the state becomes PAUSE in the same cycle as step_strobe. Output bp_hit pulses 1 cycle. Resume via pause low-high-low or single_step.
- Undefined: no bp ports, no breakpoint logic.

Test Plan:
- DWELL=4. Write 3 vectors (imm 1, 2, 3), last_step=2, loop_en=0, start -> imm 1/2/3 each held 4 cycles, 3 strobes, then done=1, imm stays 3, busy=0.
- Same table, loop_en=1 -> after step 2, cur_step=0, imm=1, loop_count=1; after 3 wraps, loop_count=3.
- Pause for 10 cycles mid-step 1 -> imm=2 held 14 cycles total. Two single_step pulses while paused -> imm 3 then done (one-shot).
- vec_we during RUN -> wr_err=1 for one cycle; table readback after stop unchanged. vec_addr=NUM_STEPS in IDLE -> wr_err.
- start and stop asserted together in RUN -> IDLE, outputs 0, dut_reset_n=0. Reset low mid-step -> all outputs 0 asynchronously; table intact on restart.
- SEQ_BREAKPOINT_EN defined, bp_addr=1 -> PAUSE entered as imm=2 appears; bp_hit pulses once; counter does not advance.

Source files
------------

// File: rtl/test_vector_sequencer.sv
// Programmable stimulus sequencer: plays a loadable vector table with dwell, loop, pause and single-step.
// Optional breakpoint support is compiled in by defining SEQ_BREAKPOINT_EN.
module test_vector_sequencer #(
    parameter int NUM_STEPS = 32,
    parameter int DWELL     = 50000000,
    parameter int IMM_W     = 16,
    parameter int EN_W      = 5,
    localparam int AW       = $clog2(NUM_STEPS),
    localparam int VEC_W    = IMM_W + 3*EN_W + 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vec_we,
    input  logic [AW-1:0]    vec_addr,
    input  logic [VEC_W-1:0] vec_wdata,
    output logic             wr_err,
    input  logic [AW-1:0]    last_step,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             single_step,
`ifdef SEQ_BREAKPOINT_EN
    input  logic             bp_en,
    input  logic [AW-1:0]    bp_addr,
    output logic             bp_hit,
`endif
    output logic [AW-1:0]    cur_step,
    output logic             step_strobe,
    output logic             busy,
    output logic             done,
    output logic [7:0]       loop_count,
    output logic             dut_reset_n,
    output logic [IMM_W-1:0] immediate,
    output logic [EN_W-1:0]  regEnables,
    output logic [EN_W-1:0]  buffAEnables,
    output logic [EN_W-1:0]  buffBEnables,
    output logic             Cin,
    output logic             regOrImmed,
    output logic [3:0]       op,
    output logic [3:0]       exop
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        logic [EN_W-1:0]  reg_en;
        logic [EN_W-1:0]  buff_a;
        logic [EN_W-1:0]  buff_b;
        logic             cin;
        logic             reg_or_imm;
        logic [3:0]       op;
        logic [3:0]       exop;
    } vec_t;

    vec_t            table_mem [NUM_STEPS];
    vec_t            out_vec;
    state_t          state;
    logic [CW-1:0]   dwell_cnt;
    logic [AW-1:0]   last_q;
    logic            addr_ok;
    logic [AW-1:0]   start_last;
    logic            active;
    logic            single_adv;
    logic            frozen;
    logic            step_now;
    logic            at_last;
    logic [AW-1:0]   next_step;
`ifdef SEQ_BREAKPOINT_EN
    logic            bp_hold;
`endif

    assign immediate    = out_vec.imm;
    assign regEnables   = out_vec.reg_en;
    assign buffAEnables = out_vec.buff_a;
    assign buffBEnables = out_vec.buff_b;
    assign Cin          = out_vec.cin;
    assign regOrImmed   = out_vec.reg_or_imm;
    assign op           = out_vec.op;
    assign exop         = out_vec.exop;

    always_comb begin
        addr_ok    = {1'b0, vec_addr} < (AW+1)'(NUM_STEPS);
        start_last = ({1'b0, last_step} > (AW+1)'(NUM_STEPS-1)) ? AW'(NUM_STEPS-1) : last_step;
        active     = (state == RUN) || (state == PAUSE);
        single_adv = (state == PAUSE) && single_step;
`ifdef SEQ_BREAKPOINT_EN
        frozen     = pause || bp_hold;
`else
        frozen     = pause;
`endif
        step_now   = single_adv || (!frozen && dwell_cnt == CW'(DWELL-1));
        at_last    = (cur_step == last_q);
        next_step  = at_last ? '0 : cur_step + AW'(1);
    end

    // Table is deliberately left out of reset so a DUT reset never loses the programmed vectors.
    always_ff @(posedge clk) begin
        if (vec_we && state == IDLE && addr_ok)
            table_mem[vec_addr] <= vec_t'(vec_wdata);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            out_vec     <= '0;
            cur_step    <= '0;
            last_q      <= '0;
            dwell_cnt   <= '0;
            loop_count  <= '0;
            step_strobe <= 1'b0;
            wr_err      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            dut_reset_n <= 1'b0;
`ifdef SEQ_BREAKPOINT_EN
            bp_hit      <= 1'b0;
            bp_hold     <= 1'b0;
`endif
        end else begin
            step_strobe <= 1'b0;
            wr_err      <= vec_we && (state != IDLE || !addr_ok);
`ifdef SEQ_BREAKPOINT_EN
            bp_hit      <= 1'b0;
`endif
            if (stop && state != IDLE) begin
                state       <= IDLE;
                out_vec     <= '0;
                cur_step    <= '0;
                dwell_cnt   <= '0;
                busy        <= 1'b0;
                done        <= 1'b0;
                dut_reset_n <= 1'b0;
`ifdef SEQ_BREAKPOINT_EN
                bp_hold     <= 1'b0;
`endif
            end else if (start && !stop && (state == IDLE || state == DONE)) begin
                state       <= RUN;
                last_q      <= start_last;
                cur_step    <= '0;
                out_vec     <= table_mem[0];
                step_strobe <= 1'b1;
                dwell_cnt   <= '0;
                loop_count  <= '0;
                busy        <= 1'b1;
                done        <= 1'b0;
                dut_reset_n <= 1'b1;
`ifdef SEQ_BREAKPOINT_EN
                bp_hold     <= 1'b0;
`endif
            end else if (active) begin
                if (step_now) begin
                    dwell_cnt <= '0;
`ifdef SEQ_BREAKPOINT_EN
                    bp_hold   <= 1'b0;
`endif
                    if (at_last && !loop_en) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state       <= single_adv ? PAUSE : RUN;
                        cur_step    <= next_step;
                        out_vec     <= table_mem[next_step];
                        step_strobe <= 1'b1;
                        if (at_last && loop_count != 8'hFF)
                            loop_count <= loop_count + 8'd1;
`ifdef SEQ_BREAKPOINT_EN
                        if (!single_adv && bp_en && next_step == bp_addr) begin
                            state   <= PAUSE;
                            bp_hit  <= 1'b1;
                            bp_hold <= 1'b1;
                        end
`endif
                    end
                end else if (frozen) begin
                    // A breakpoint pause needs a full pause high-then-low before running again.
                    state <= PAUSE;
`ifdef SEQ_BREAKPOINT_EN
                    if (pause)
                        bp_hold <= 1'b0;
`endif
                end else begin
                    state     <= RUN;
                    dwell_cnt <= dwell_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_test_vector_sequencer.sv
// Scoreboard bench for test_vector_sequencer: expected vector appearances are queued by the stimulus
// and popped by a monitor on every step_strobe; the expected schedule comes from dwell arithmetic.
module tb_test_vector_sequencer;
    localparam int NS    = 6;
    localparam int DW    = 4;
    localparam int IMM_W = 16;
    localparam int EN_W  = 5;
    localparam int AW    = $clog2(NS);
    localparam int VEC_W = IMM_W + 3*EN_W + 10;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             vec_we = 1'b0;
    logic [AW-1:0]    vec_addr = '0;
    logic [VEC_W-1:0] vec_wdata = '0;
    logic             wr_err;
    logic [AW-1:0]    last_step = '0;
    logic             loop_en = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             pause = 1'b0;
    logic             single_step = 1'b0;
    logic [AW-1:0]    cur_step;
    logic             step_strobe;
    logic             busy;
    logic             done;
    logic [7:0]       loop_count;
    logic             dut_reset_n;
    logic [IMM_W-1:0] immediate;
    logic [EN_W-1:0]  regEnables;
    logic [EN_W-1:0]  buffAEnables;
    logic [EN_W-1:0]  buffBEnables;
    logic             Cin;
    logic             regOrImmed;
    logic [3:0]       op;
    logic [3:0]       exop;
`ifdef SEQ_BREAKPOINT_EN
    logic             bp_hit;
`endif

    test_vector_sequencer #(.NUM_STEPS(NS), .DWELL(DW), .IMM_W(IMM_W), .EN_W(EN_W)) dut (
        .clk(clk), .reset(reset), .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
        .wr_err(wr_err), .last_step(last_step), .loop_en(loop_en), .start(start), .stop(stop),
        .pause(pause), .single_step(single_step),
`ifdef SEQ_BREAKPOINT_EN
        .bp_en(1'b0), .bp_addr('0), .bp_hit(bp_hit),
`endif
        .cur_step(cur_step), .step_strobe(step_strobe), .busy(busy), .done(done),
        .loop_count(loop_count), .dut_reset_n(dut_reset_n), .immediate(immediate),
        .regEnables(regEnables), .buffAEnables(buffAEnables), .buffBEnables(buffBEnables),
        .Cin(Cin), .regOrImmed(regOrImmed), .op(op), .exop(exop)
    );

    wire [VEC_W-1:0] out_word = {immediate, regEnables, buffAEnables, buffBEnables, Cin, regOrImmed, op, exop};

    typedef struct {
        int               step;
        logic [VEC_W-1:0] vec;
        int               lc;
        int               at;
    } exp_t;

    exp_t             sbq[$];
    logic [VEC_W-1:0] model_tab [NS];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every new vector on the outputs must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && step_strobe) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe: got step %0d, expected no strobe (cycle %0d)", cur_step, cyc);
            end else begin
                e = sbq.pop_front();
                checkOutput("strobe_step", cur_step, e.step);
                checkOutput("strobe_vector", out_word, e.vec);
                checkOutput("strobe_loops", loop_count, e.lc);
                checkOutput("strobe_cycle", cyc, e.at);
            end
        end
    end

    function automatic int clampLast(input int x);
        return (x > NS-1) ? NS-1 : x;
    endfunction

    task automatic pushStep(input int step, input int lc, input int at);
        exp_t e;
        e.step = step;
        e.vec  = model_tab[step];
        e.lc   = lc;
        e.at   = at;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic ss);
        start = st;
        stop = sp;
        single_step = ss;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        single_step = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic writeVec(input int addr, input logic [VEC_W-1:0] data, input bit ok);
        vec_we = 1'b1;
        vec_addr = AW'(addr);
        vec_wdata = data;
        @(negedge clk);
        vec_we = 1'b0;
        checkOutput("wr_err", wr_err, ok ? 0 : 1);
        if (ok) model_tab[addr] = data;
    endtask

    function automatic logic [VEC_W-1:0] randVec();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[VEC_W-1:0];
    endfunction

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_word"}, out_word, 0);
        checkOutput({tag, "_step"}, cur_step, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_dut_rst_n"}, dut_reset_n, 0);
    endtask

    task automatic runOneShot(input int last_in, input int pstep, input int plen);
        int L, t0, tdone;
        L = clampLast(last_in);
        last_step = AW'(last_in);
        loop_en = 1'b0;
        t0 = cyc + 1;
        for (int k = 0; k <= L; k++)
            pushStep(k, 0, t0 + k*DW + ((plen > 0 && k > pstep) ? plen : 0));
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("run_busy", busy, 1);
        checkOutput("run_dut_rst_n", dut_reset_n, 1);
        if (plen > 0) begin
            waitUntil(t0 + pstep*DW + 1);
            pause = 1'b1;
            repeat (plen) @(negedge clk);
            pause = 1'b0;
        end
        tdone = t0 + (L+1)*DW + plen;
        waitUntil(tdone - 1);
        checkOutput("done_early", done, 0);
        @(negedge clk);
        checkOutput("done", done, 1);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_step", cur_step, L);
        checkOutput("done_word", out_word, model_tab[L]);
        checkOutput("oneshot_drain", sbq.size(), 0);
    endtask

    task automatic runLoop(input int last_in, input int wraps, input bit do_wr);
        int L, t0, n;
        L = clampLast(last_in);
        last_step = AW'(last_in);
        loop_en = 1'b1;
        t0 = cyc + 1;
        n = 0;
        for (int w = 0; w < wraps; w++)
            for (int k = 0; k <= L; k++) begin
                pushStep(k, w, t0 + n*DW);
                n++;
            end
        pushStep(0, wraps, t0 + n*DW);
        applyStimulus(1'b1, 1'b0, 1'b0);
        if (do_wr) writeVec(0, randVec(), 1'b0);
        waitUntil(t0 + n*DW);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkIdleOutputs("stop");
        checkOutput("loop_drain", sbq.size(), 0);
    endtask

    task automatic runStepTest();
        int t0;
        last_step = AW'(2);
        loop_en = 1'b0;
        t0 = cyc + 1;
        pushStep(0, 0, t0);
        pushStep(1, 0, t0 + DW);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil(t0 + DW + 1);
        pause = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("paused_step", cur_step, 1);
        checkOutput("paused_busy", busy, 1);
        pushStep(2, 0, cyc + 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("ss_done", done, 1);
        checkOutput("ss_busy", busy, 0);
        checkOutput("ss_word", out_word, model_tab[2]);
        pause = 1'b0;
        repeat (2*DW) @(negedge clk);
        checkOutput("ss_hold_word", out_word, model_tab[2]);
        checkOutput("ss_drain", sbq.size(), 0);
    endtask

    task automatic runResetTest();
        int t0;
        last_step = AW'(4);
        loop_en = 1'b1;
        t0 = cyc + 1;
        pushStep(0, 0, t0);
        pushStep(1, 0, t0 + DW);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntil(t0 + DW + 2);
        #2 reset = 1'b0;
        #1;
        checkIdleOutputs("async_rst");
        checkOutput("async_rst_loops", loop_count, 0);
        checkOutput("async_rst_strobe", step_strobe, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_drain", sbq.size(), 0);
    endtask

    initial begin
        logic [VEC_W-1:0] v;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        checkOutput("reset_loops", loop_count, 0);
        checkOutput("reset_wr_err", wr_err, 0);
        checkOutput("reset_strobe", step_strobe, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NS; i++) begin
            v = randVec();
            if (i < 3) v[VEC_W-1 -: IMM_W] = IMM_W'(i + 1);
            writeVec(i, v, 1'b1);
        end
        writeVec(NS, randVec(), 1'b0);
        writeVec(NS + 1, randVec(), 1'b0);

        runOneShot(2, 0, 0);
        runOneShot(2, 1, 10);
        runLoop(2, 3, 1'b1);
        runLoop(0, 2, 1'b0);
        runOneShot(7, 0, 0);
        runStepTest();
        runResetTest();
        runOneShot(2, 0, 0);

        for (int it = 0; it < 12; it++) begin
            int L, nw, a;
            applyStimulus(1'b0, 1'b1, 1'b0);
            nw = $urandom_range(0, 2);
            for (int j = 0; j < nw; j++) begin
                a = $urandom_range(0, 7);
                writeVec(a, randVec(), a < NS);
            end
            if ($urandom_range(0, 1) == 0) begin
                L = $urandom_range(0, 7);
                runOneShot(L, $urandom_range(0, clampLast(L)),
                           ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0);
            end else begin
                runLoop($urandom_range(0, 7), $urandom_range(1, 3), $urandom_range(0, 1) == 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
